// File: rtl/d2d_l2_arbiter_pkg.sv
// rtl/d2d_l2_arbiter_pkg.sv - shared types and constants for the die-to-die L2 request arbiter
package d2d_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int DEF_NCH = 2;
  localparam int DEF_AW  = 32;
  localparam int DEF_DW  = 32;

  // Index width that stays legal when there is only one channel.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/d2d_l2_arbiter_if.sv
// rtl/d2d_l2_arbiter_if.sv - requester channels and shared L2 link bundle
interface d2d_l2_arbiter_if
  import d2d_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW
);

  logic [NCH-1:0]    ch_req_i;
  logic [NCH*AW-1:0] ch_addr_i;
  logic [NCH-1:0]    ch_we_i;
  logic [NCH*DW-1:0] ch_wdat_i;
  logic [NCH-1:0]    ch_rsp_o;
  logic [DW-1:0]     ch_rdat_o;
  logic              ch_err_o;
  logic              l2_valid_o;
  logic [AW-1:0]     l2_addr_o;
  logic              l2_we_o;
  logic [DW-1:0]     l2_dat_o;
  logic              l2_valid_i;
  logic [DW-1:0]     l2_dat_i;

  // The arbiter is master of the link and responder to the channels.
  modport master (
    input  ch_req_i, ch_addr_i, ch_we_i, ch_wdat_i, l2_valid_i, l2_dat_i,
    output ch_rsp_o, ch_rdat_o, ch_err_o, l2_valid_o, l2_addr_o, l2_we_o, l2_dat_o
  );

  modport slave (
    output ch_req_i, ch_addr_i, ch_we_i, ch_wdat_i, l2_valid_i, l2_dat_i,
    input  ch_rsp_o, ch_rdat_o, ch_err_o, l2_valid_o, l2_addr_o, l2_we_o, l2_dat_o
  );

endinterface

// File: rtl/d2d_l2_arbiter_rr_arbiter.sv
// rtl/d2d_l2_arbiter_rr_arbiter.sv - combinational round-robin / fixed-priority channel picker
module rr_arbiter
  import d2d_pkg::*;
#(
  parameter  int NCH      = DEF_NCH,
  parameter  int ARB_MODE = ARB_RR,
  localparam int IW       = idx_w(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o,
  output logic           any_o
);

  // Fixed priority is a round-robin search that always starts at channel 0.
  function automatic int slot(input int i, input logic [IW-1:0] ptr);
    int c;
    c = i + ((ARB_MODE == ARB_FIXED) ? 0 : int'(ptr));
    return (c >= NCH) ? c - NCH : c;
  endfunction

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!any_o && req_i[slot(i, ptr_i)]) begin
        any_o                  = 1'b1;
        idx_o                  = IW'(slot(i, ptr_i));
        gnt_o[slot(i, ptr_i)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/d2d_l2_arbiter.sv
// rtl/d2d_l2_arbiter.sv - single-outstanding arbiter merging L1 requesters onto one die-to-die L2 link
module d2d_l2_arbiter
  import d2d_pkg::*;
#(
  parameter  int NCH      = DEF_NCH,
  parameter  int AW       = DEF_AW,
  parameter  int DW       = DEF_DW,
  parameter  int ARB_MODE = ARB_RR,
  parameter  int TIMEOUT  = 255,
  localparam int IW       = idx_w(NCH),
  localparam int CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  d2d_l2_arbiter_if.master  bus,
  output logic              busy_o,
  output logic [IW-1:0]     grant_o
);

  state_e         state_q;
  logic [IW-1:0]  ptr_q, grant_q, ptr_d;
  logic [NCH-1:0] gnt_q, rsp_q;
  logic [CW-1:0]  cnt_q;
  logic           l2_valid_q, l2_we_q, err_q, busy_q;
  logic [AW-1:0]  l2_addr_q;
  logic [DW-1:0]  l2_dat_q, rdat_q;

  logic [NCH-1:0] arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_any;
  logic           timeout_hit;

  rr_arbiter #(.NCH(NCH), .ARB_MODE(ARB_MODE)) u_arb (
    .req_i (bus.ch_req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign ptr_d       = (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      gnt_q      <= '0;
      rsp_q      <= '0;
      cnt_q      <= '0;
      l2_valid_q <= 1'b0;
      l2_we_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      l2_addr_q  <= '0;
      l2_dat_q   <= '0;
      rdat_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q    <= REQ;
            busy_q     <= 1'b1;
            l2_valid_q <= 1'b1;
            l2_addr_q  <= bus.ch_addr_i[arb_idx*AW +: AW];
            l2_we_q    <= bus.ch_we_i[arb_idx];
            l2_dat_q   <= bus.ch_wdat_i[arb_idx*DW +: DW];
            grant_q    <= arb_idx;
            gnt_q      <= arb_gnt;
            ptr_q      <= ptr_d;
            cnt_q      <= '0;
          end
        end
        REQ: begin
          // A response in the timeout cycle still wins over the error completion.
          if (bus.l2_valid_i) begin
            state_q    <= RSP;
            l2_valid_q <= 1'b0;
            rdat_q     <= bus.l2_dat_i;
            rsp_q      <= gnt_q;
            err_q      <= 1'b0;
          end else if (timeout_hit) begin
            state_q    <= RSP;
            l2_valid_q <= 1'b0;
            rdat_q     <= '0;
            rsp_q      <= gnt_q;
            err_q      <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RSP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rsp_q   <= '0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ch_rsp_o   = rsp_q;
  assign bus.ch_rdat_o  = rdat_q;
  assign bus.ch_err_o   = err_q;
  assign bus.l2_valid_o = l2_valid_q;
  assign bus.l2_addr_o  = l2_addr_q;
  assign bus.l2_we_o    = l2_we_q;
  assign bus.l2_dat_o   = l2_dat_q;
  assign busy_o         = busy_q;
  assign grant_o        = grant_q;

endmodule
